// File: rtl/pwm_pkg.sv
// Shared constants for the multi-channel PWM: counter mode encodings and
// the count-direction state of the center-aligned counter.
package pwm_pkg;

  localparam logic PWM_MODE_EDGE   = 1'b0;
  localparam logic PWM_MODE_CENTER = 1'b1;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

endpackage

// File: rtl/pwm_ch_out.sv
// One PWM channel: compares the active duty against the shared counter,
// applies the live polarity and registers the result for a glitch-free pin.
module pwm_ch_out #(
  parameter int W = 10
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         tick_i,
  input  logic         en_i,
  input  logic [W-1:0] duty_i,
  input  logic [W-1:0] cnt_i,
  input  logic         pol_i,
  output logic         pwm_o
);

  logic pwm_q;
  logic pwm_d;

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    pwm_d = pwm_q;
    if (!en_i) begin
      pwm_d = pol_i;
    end else if (tick_i) begin
      pwm_d = (duty_i > cnt_i) ^ pol_i;
    end
  end

  // NOTE: state flops use non-blocking assignments so all flops update together.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) pwm_q <= 1'b0;
    else     pwm_q <= pwm_d;
  end

  assign pwm_o = pwm_q;

endmodule

// File: rtl/pwm_multi_ch.sv
// Multi-channel PWM: one shared edge/center-aligned period counter, double-
// buffered mode/period/duty that switch only at a period boundary.
module pwm_multi_ch
  import pwm_pkg::*;
#(
  parameter int CH = 4,
  parameter int W  = 10
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            CE,
  input  logic            EN,
  input  logic            MODE,
  input  logic [W-1:0]    PERIOD,
  input  logic [CH*W-1:0] DUTY,
  input  logic [CH-1:0]   POL,
  input  logic            UPD,
  output logic [CH-1:0]   PWM_P,
  output logic            PRD_STB,
  output logic            UPD_ACK,
  output logic [W-1:0]    CNT_OUT
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0]    cnt_q, cnt_d;
  dir_e            dir_q, dir_d;
  logic            pend_q, pend_d;
  logic            sh_mode_q, sh_mode_d;
  logic [W-1:0]    sh_period_q, sh_period_d;
  logic [CH*W-1:0] sh_duty_q, sh_duty_d;
  logic            act_mode_q, act_mode_d;
  logic [W-1:0]    act_period_q, act_period_d;
  logic [CH*W-1:0] act_duty_q, act_duty_d;

  logic            tick;
  logic            boundary;
  logic            xfer;
  logic [W-1:0]    ctr_period;

  assign tick = CE & EN;

  // A zero period in center mode would never turn around; run it as P=1.
  assign ctr_period = (act_mode_q == PWM_MODE_CENTER && act_period_q == '0) ? ONE
                                                                             : act_period_q;
  assign boundary   = (act_mode_q == PWM_MODE_EDGE) ? (cnt_q == act_period_q)
                                                     : (dir_q == DIR_DOWN && cnt_q == '0);
  assign xfer       = tick & boundary & pend_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q        <= '0;
      dir_q        <= DIR_UP;
      pend_q       <= 1'b0;
      sh_mode_q    <= PWM_MODE_EDGE;
      sh_period_q  <= '0;
      sh_duty_q    <= '0;
      act_mode_q   <= PWM_MODE_EDGE;
      act_period_q <= '0;
      act_duty_q   <= '0;
    end else begin
      cnt_q        <= cnt_d;
      dir_q        <= dir_d;
      pend_q       <= pend_d;
      sh_mode_q    <= sh_mode_d;
      sh_period_q  <= sh_period_d;
      sh_duty_q    <= sh_duty_d;
      act_mode_q   <= act_mode_d;
      act_period_q <= act_period_d;
      act_duty_q   <= act_duty_d;
    end
  end

  always_comb begin
    cnt_d        = cnt_q;
    dir_d        = dir_q;
    sh_mode_d    = sh_mode_q;
    sh_period_d  = sh_period_q;
    sh_duty_d    = sh_duty_q;
    act_mode_d   = act_mode_q;
    act_period_d = act_period_q;
    act_duty_d   = act_duty_q;

    if (UPD) begin
      sh_mode_d   = MODE;
      sh_period_d = PERIOD;
      sh_duty_d   = DUTY;
    end
    // A capture on the boundary cycle itself must survive for the next boundary.
    pend_d = UPD | (pend_q & EN & ~xfer);

    if (!EN || xfer) begin
      act_mode_d   = sh_mode_q;
      act_period_d = sh_period_q;
      act_duty_d   = sh_duty_q;
    end

    if (!EN) begin
      cnt_d = '0;
      dir_d = DIR_UP;
    end else if (tick) begin
      if (xfer) begin
        cnt_d = '0;
        dir_d = DIR_UP;
      end else if (act_mode_q == PWM_MODE_EDGE) begin
        cnt_d = boundary ? '0 : cnt_q + ONE;
        dir_d = DIR_UP;
      end else if (dir_q == DIR_UP) begin
        if (cnt_q >= ctr_period - ONE) dir_d = DIR_DOWN;
        else                           cnt_d = cnt_q + ONE;
      end else begin
        if (cnt_q == '0) dir_d = DIR_UP;
        else             cnt_d = cnt_q - ONE;
      end
    end
  end

  // Strobes are forced low while RST is held: the reset state is itself a boundary.
  always_comb begin
    PRD_STB = ~RST & tick & boundary;
    UPD_ACK = ~RST & xfer;
    CNT_OUT = cnt_q;
  end

  for (genvar i = 0; i < CH; i++) begin : g_ch
    pwm_ch_out #(.W(W)) u_ch (
      .CLK    (CLK),
      .RST    (RST),
      .tick_i (tick),
      .en_i   (EN),
      .duty_i (act_duty_q[i*W +: W]),
      .cnt_i  (cnt_q),
      .pol_i  (POL[i]),
      .pwm_o  (PWM_P[i])
    );
  end

endmodule

// File: tb/tb_pwm_multi_ch.sv
// Directed bench for pwm_multi_ch (CH=4, W=8): a table of steady-state duty
// vectors plus hand sequences for counting, buffered updates and reset.
module tb_pwm_multi_ch;

  localparam int CH = 4;
  localparam int W  = 8;

  logic            CLK = 1'b0;
  logic            RST = 1'b1;
  logic            CE = 1'b1;
  logic            EN = 1'b1;
  logic            MODE = 1'b0;
  logic [W-1:0]    PERIOD = '0;
  logic [CH*W-1:0] DUTY = '0;
  logic [CH-1:0]   POL = '0;
  logic            UPD = 1'b0;
  logic [CH-1:0]   PWM_P;
  logic            PRD_STB;
  logic            UPD_ACK;
  logic [W-1:0]    CNT_OUT;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ce_div = 1;

  typedef struct {
    logic               mode;
    logic [7:0]         p;
    logic [31:0]        duty;   // {D3,D2,D1,D0}
    logic [3:0]         pol;
    int                 div;
    int                 win;
    logic [3:0][7:0]    hi;     // {hi3,hi2,hi1,hi0} high clocks in the window
    int                 stb;
  } vec_t;

  vec_t vecs[5];
  int   exp_cnt_c[8] = '{0, 1, 2, 3, 3, 2, 1, 0};
  int   exp_pwm_c[8] = '{1, 1, 1, 0, 0, 0, 0, 1};
  int   exp_cnt_m[8] = '{0, 1, 2, 3, 3, 2, 1, 0};

  pwm_multi_ch #(.CH(CH), .W(W)) dut (
    .CLK     (CLK),
    .RST     (RST),
    .CE      (CE),
    .EN      (EN),
    .MODE    (MODE),
    .PERIOD  (PERIOD),
    .DUTY    (DUTY),
    .POL     (POL),
    .UPD     (UPD),
    .PWM_P   (PWM_P),
    .PRD_STB (PRD_STB),
    .UPD_ACK (UPD_ACK),
    .CNT_OUT (CNT_OUT)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 2 time units after the edge.
  task automatic step();
    @(posedge CLK);
    #1;
    cyc++;
    CE = ((cyc % ce_div) == 0);
    #1;
  endtask

  task automatic config_pwm(input logic m, input logic [7:0] p, input logic [31:0] d,
                            input logic [3:0] pol, input int div);
    EN     = 1'b0;
    ce_div = div;
    MODE   = m;
    PERIOD = p;
    DUTY   = d;
    POL    = pol;
    UPD    = 1'b1;
    step();
    UPD = 1'b0;
    step();
    step();
    EN = 1'b1;
  endtask

  task automatic wait_stb(input int budget, input string name);
    int n = 1;
    step();
    while (!PRD_STB && n < budget) begin
      step();
      n++;
    end
    if (!PRD_STB) check({name, "_stb_timeout"}, 0, 1);
  endtask

  initial begin
    int hi_cnt[4];
    int stb_cnt;
    int ack_cnt;

    vecs[0] = '{1'b0, 8'd9, {8'd3, 8'd10, 8'd0, 8'd3}, 4'b1000, 1, 20,
                {8'd14, 8'd20, 8'd0, 8'd6}, 2};
    vecs[1] = '{1'b1, 8'd4, {8'd9, 8'd4, 8'd0, 8'd2}, 4'b0000, 1, 16,
                {8'd16, 8'd16, 8'd0, 8'd8}, 2};
    vecs[2] = '{1'b0, 8'd9, {8'd5, 8'd1, 8'd9, 8'd3}, 4'b0000, 4, 40,
                {8'd20, 8'd4, 8'd36, 8'd12}, 1};
    vecs[3] = '{1'b1, 8'd0, {8'd0, 8'd1, 8'd0, 8'd1}, 4'b0011, 1, 8,
                {8'd0, 8'd8, 8'd8, 8'd0}, 4};
    vecs[4] = '{1'b0, 8'd0, {8'd0, 8'd255, 8'd1, 8'd0}, 4'b0000, 1, 5,
                {8'd0, 8'd5, 8'd5, 8'd0}, 5};

    // Reset state while EN and CE are both high.
    #12;
    check("rst_pwm", int'(PWM_P), 0);
    check("rst_stb", int'(PRD_STB), 0);
    check("rst_ack", int'(UPD_ACK), 0);
    check("rst_cnt", int'(CNT_OUT), 0);
    #1 RST = 1'b0;

    // Steady-state duty table.
    for (int v = 0; v < 5; v++) begin
      config_pwm(vecs[v].mode, vecs[v].p, vecs[v].duty, vecs[v].pol, vecs[v].div);
      for (int k = 0; k < vecs[v].win; k++) step();
      for (int c = 0; c < CH; c++) hi_cnt[c] = 0;
      stb_cnt = 0;
      for (int k = 0; k < vecs[v].win; k++) begin
        step();
        for (int c = 0; c < CH; c++) hi_cnt[c] += int'(PWM_P[c]);
        stb_cnt += int'(PRD_STB);
      end
      for (int c = 0; c < CH; c++)
        check($sformatf("v%0d_ch%0d_high", v, c), hi_cnt[c], int'(vecs[v].hi[c]));
      check($sformatf("v%0d_stb", v), stb_cnt, vecs[v].stb);
    end

    // Center mode P=4: counter sequence and delayed output over one period.
    config_pwm(1'b1, 8'd4, {8'd0, 8'd0, 8'd0, 8'd2}, 4'b0000, 1);
    wait_stb(40, "center");
    for (int k = 0; k < 8; k++) begin
      step();
      check($sformatf("center_cnt%0d", k), int'(CNT_OUT), exp_cnt_c[k]);
      check($sformatf("center_pwm%0d", k), int'(PWM_P[0]), exp_pwm_c[k]);
      check($sformatf("center_stb%0d", k), int'(PRD_STB), (k == 7) ? 1 : 0);
    end

    // Mid-period duty change 3 -> 7: old period completes, then 7 high clocks.
    config_pwm(1'b0, 8'd9, {8'd0, 8'd0, 8'd0, 8'd3}, 4'b0000, 1);
    wait_stb(40, "midupd");
    hi_cnt[0] = 0;
    ack_cnt = 0;
    for (int k = 1; k <= 10; k++) begin
      step();
      hi_cnt[0] += int'(PWM_P[0]);
      if (k < 10) ack_cnt += int'(UPD_ACK);
      UPD = 1'b0;
      if (k == 4) begin
        DUTY[7:0] = 8'd7;
        UPD = 1'b1;
      end
    end
    check("midupd_stb", int'(PRD_STB), 1);
    check("midupd_ack", int'(UPD_ACK), 1);
    check("midupd_early_ack", ack_cnt, 0);
    check("midupd_old_high", hi_cnt[0], 3);
    hi_cnt[0] = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      hi_cnt[0] += int'(PWM_P[0]);
    end
    check("midupd_new_high", hi_cnt[0], 7);

    // UPD on the boundary cycle switching edge -> center.
    config_pwm(1'b0, 8'd9, {8'd0, 8'd0, 8'd0, 8'd3}, 4'b0000, 1);
    wait_stb(40, "modesw");
    check("modesw_no_ack_now", int'(UPD_ACK), 0);
    MODE   = 1'b1;
    PERIOD = 8'd4;
    UPD    = 1'b1;
    ack_cnt = 0;
    for (int k = 1; k <= 10; k++) begin
      step();
      UPD = 1'b0;
      if (k < 10) ack_cnt += int'(UPD_ACK);
    end
    check("modesw_early_ack", ack_cnt, 0);
    check("modesw_stb", int'(PRD_STB), 1);
    check("modesw_ack", int'(UPD_ACK), 1);
    check("modesw_last_cnt", int'(CNT_OUT), 9);
    for (int k = 0; k < 8; k++) begin
      step();
      check($sformatf("modesw_cnt%0d", k), int'(CNT_OUT), exp_cnt_m[k]);
    end

    // Reset on a boundary tick with CE every 4th clock.
    config_pwm(1'b0, 8'd9, {8'd9, 8'd9, 8'd9, 8'd9}, 4'b0000, 4);
    wait_stb(200, "rstmid");
    check("rstmid_pre_pwm", int'(PWM_P), 15);
    check("rstmid_pre_cnt", int'(CNT_OUT), 9);
    #3 RST = 1'b1;
    #1;
    check("rstmid_pwm", int'(PWM_P), 0);
    check("rstmid_stb", int'(PRD_STB), 0);
    check("rstmid_cnt", int'(CNT_OUT), 0);
    check("rstmid_ack", int'(UPD_ACK), 0);
    #2 RST = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
